// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback mux with x0 suppression and a retired-instruction counter.
// Optional load byte/half alignment and sign/zero extension is enabled by defining WB_LOAD_ALIGN_EN.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_wb,
  input  logic            flush_wb,
  input  logic            valid_mem,
  input  logic            RegWrite_mem,
  input  logic [4:0]      rd_mem,
  input  logic [1:0]      WbSel_mem,
  input  logic [2:0]      LoadType_mem,
  input  logic [1:0]      addr_lo_mem,
  input  logic [XLEN-1:0] ALUResult_mem,
  input  logic [XLEN-1:0] memDout_mem,
  input  logic [XLEN-1:0] PCPlus4_mem,
  input  logic [XLEN-1:0] Imm_mem,
  output logic            valid_wb,
  output logic            RegWrite_wb,
  output logic [4:0]      rd_wb,
  output logic [XLEN-1:0] RegWriteData_wb,
  output logic [63:0]     instret
);

  logic            valid_q;
  logic            regwrite_q;
  logic [4:0]      rd_q;
  logic [1:0]      wbsel_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] mem_q;
  logic [XLEN-1:0] pc4_q;
  logic [XLEN-1:0] imm_q;
  logic [63:0]     instret_q;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wbsel_q    <= '0;
      alu_q      <= '0;
      mem_q      <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (flush_wb) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wbsel_q    <= '0;
      alu_q      <= '0;
      mem_q      <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (!stall_wb) begin
      valid_q    <= valid_mem;
      regwrite_q <= RegWrite_mem;
      rd_q       <= rd_mem;
      wbsel_q    <= WbSel_mem;
      alu_q      <= ALUResult_mem;
      mem_q      <= memDout_mem;
      pc4_q      <= PCPlus4_mem;
      imm_q      <= Imm_mem;
    end
  end

`ifdef WB_LOAD_ALIGN_EN
  logic [2:0] load_type_q;
  logic [1:0] addr_lo_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_type_q <= '0;
      addr_lo_q   <= '0;
    end else if (flush_wb) begin
      load_type_q <= '0;
      addr_lo_q   <= '0;
    end else if (!stall_wb) begin
      load_type_q <= LoadType_mem;
      addr_lo_q   <= addr_lo_mem;
    end
  end

  // Halves are chosen by addr_lo[1] only; misaligned half offsets fold onto the aligned half.
  always_comb begin
    byte_sel  = mem_q[{addr_lo_q, 3'b000} +: 8];
    half_sel  = addr_lo_q[1] ? mem_q[31:16] : mem_q[15:0];
    load_data = mem_q;
    case (load_type_q)
      3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = mem_q;
    endcase
  end
`else
  logic unused_load_bits;
  assign unused_load_bits = ^{LoadType_mem, addr_lo_mem};

  always_comb begin
    load_data = mem_q;
  end
`endif

  // Select codes beyond the configured source count fall back to the ALU result.
  always_comb begin
    wb_data = alu_q;
    case (wbsel_q)
      2'd1:    if (NSRC > 1) wb_data = load_data;
      2'd2:    if (NSRC > 2) wb_data = pc4_q;
      2'd3:    if (NSRC > 3) wb_data = imm_q;
      default: wb_data = alu_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (valid_q && !stall_wb) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign valid_wb        = valid_q;
  assign RegWrite_wb     = regwrite_q & valid_q & (rd_q != 5'd0);
  assign rd_wb           = rd_q;
  assign RegWriteData_wb = wb_data;
  assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected WB records are queued when MEM inputs are driven and
// checked when they reach the WB outputs; a second NSRC=2 instance checks the reduced mux.
module tb_wb_stage;

  localparam int XLEN = 32;
`ifdef WB_LOAD_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic            valid;
    logic            regwrite;
    logic [4:0]      rd;
    logic [XLEN-1:0] data4;
    logic [XLEN-1:0] data2;
  } wb_rec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall_wb = 1'b0;
  logic            flush_wb = 1'b0;
  logic            valid_mem = 1'b0;
  logic            RegWrite_mem = 1'b0;
  logic [4:0]      rd_mem = '0;
  logic [1:0]      WbSel_mem = '0;
  logic [2:0]      LoadType_mem = '0;
  logic [1:0]      addr_lo_mem = '0;
  logic [XLEN-1:0] ALUResult_mem = '0;
  logic [XLEN-1:0] memDout_mem = '0;
  logic [XLEN-1:0] PCPlus4_mem = '0;
  logic [XLEN-1:0] Imm_mem = '0;
  logic            valid_wb, valid_wb2;
  logic            RegWrite_wb, RegWrite_wb2;
  logic [4:0]      rd_wb, rd_wb2;
  logic [XLEN-1:0] RegWriteData_wb, RegWriteData_wb2;
  logic [63:0]     instret, instret2;

  wb_rec_t    exp_q[$];
  wb_rec_t    cur;
  logic [63:0] exp_instret;
  int          assert_count = 0;
  int          fail_count = 0;

  wb_stage #(.XLEN(XLEN), .NSRC(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_wb(stall_wb), .flush_wb(flush_wb),
    .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem), .rd_mem(rd_mem),
    .WbSel_mem(WbSel_mem), .LoadType_mem(LoadType_mem), .addr_lo_mem(addr_lo_mem),
    .ALUResult_mem(ALUResult_mem), .memDout_mem(memDout_mem),
    .PCPlus4_mem(PCPlus4_mem), .Imm_mem(Imm_mem),
    .valid_wb(valid_wb), .RegWrite_wb(RegWrite_wb), .rd_wb(rd_wb),
    .RegWriteData_wb(RegWriteData_wb), .instret(instret)
  );

  wb_stage #(.XLEN(XLEN), .NSRC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_wb(stall_wb), .flush_wb(flush_wb),
    .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem), .rd_mem(rd_mem),
    .WbSel_mem(WbSel_mem), .LoadType_mem(LoadType_mem), .addr_lo_mem(addr_lo_mem),
    .ALUResult_mem(ALUResult_mem), .memDout_mem(memDout_mem),
    .PCPlus4_mem(PCPlus4_mem), .Imm_mem(Imm_mem),
    .valid_wb(valid_wb2), .RegWrite_wb(RegWrite_wb2), .rd_wb(rd_wb2),
    .RegWriteData_wb(RegWriteData_wb2), .instret(instret2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, " valid"}, {63'd0, valid_wb}, {63'd0, cur.valid});
    check_val({tag, " regwrite"}, {63'd0, RegWrite_wb}, {63'd0, cur.regwrite});
    check_val({tag, " rd"}, {59'd0, rd_wb}, {59'd0, cur.rd});
    check_val({tag, " data"}, {32'd0, RegWriteData_wb}, {32'd0, cur.data4});
    check_val({tag, " data_nsrc2"}, {32'd0, RegWriteData_wb2}, {32'd0, cur.data2});
    check_val({tag, " instret"}, instret, exp_instret);
  endtask

  // Drive one MEM-stage instruction and queue the WB record it should produce.
  task automatic apply_stimulus(input logic v, input logic rw, input logic [4:0] rd,
                                input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] alo,
                                input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem,
                                input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] imm,
                                input logic [XLEN-1:0] exp4, input logic [XLEN-1:0] exp2);
    wb_rec_t r;
    valid_mem = v; RegWrite_mem = rw; rd_mem = rd; WbSel_mem = sel;
    LoadType_mem = lt; addr_lo_mem = alo; ALUResult_mem = alu; memDout_mem = mem;
    PCPlus4_mem = pc4; Imm_mem = imm;
    r.valid = v;
    r.regwrite = rw && v && (rd != 5'd0);
    r.rd = rd;
    r.data4 = exp4;
    r.data2 = exp2;
    exp_q.push_back(r);
  endtask

  // One clock edge with the given stall/flush, then check against the scoreboard.
  task automatic cycle(input string tag, input logic s, input logic f);
    wb_rec_t bubble;
    bubble.valid = 1'b0; bubble.regwrite = 1'b0; bubble.rd = '0;
    bubble.data4 = '0; bubble.data2 = '0;
    stall_wb = s;
    flush_wb = f;
    if (cur.valid && !s) exp_instret = exp_instret + 64'd1;
    @(posedge clk);
    #1;
    if (f) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      cur = bubble;
    end else if (!s) begin
      assert_count++;
      assert (exp_q.size() > 0) else begin
        fail_count++;
        $error("[TB] FAIL %s scoreboard: observed empty queue expected an entry", tag);
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
    end
    stall_wb = 1'b0;
    flush_wb = 1'b0;
    check_output(tag);
  endtask

  initial begin
    cur.valid = 1'b0; cur.regwrite = 1'b0; cur.rd = '0; cur.data4 = '0; cur.data2 = '0;
    exp_instret = '0;

    // Reset held with busy inputs: everything stays zero.
    valid_mem = 1'b1; RegWrite_mem = 1'b1; rd_mem = 5'd3; ALUResult_mem = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset");
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(1, 1, 5'd5, 2'd0, 3'b010, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 32'h0,
                   32'h0000_1234, 32'h0000_1234);
    cycle("alu", 0, 0);
    apply_stimulus(1, 1, 5'd6, 2'd2, 3'b010, 2'd0, 32'h0000_0055, 32'h0, 32'h0000_0100, 32'h0,
                   32'h0000_0100, 32'h0000_0055);
    cycle("pc4", 0, 0);
    apply_stimulus(1, 1, 5'd7, 2'd3, 3'b010, 2'd0, 32'h0000_0055, 32'h0, 32'h0, 32'hABCD_E000,
                   32'hABCD_E000, 32'h0000_0055);
    cycle("imm", 0, 0);

    apply_stimulus(1, 1, 5'd8, 2'd1, 3'b000, 2'd0, 32'h1, 32'h80FF_7F81, 32'h0, 32'h0,
                   ALIGN ? 32'hFFFF_FF81 : 32'h80FF_7F81, ALIGN ? 32'hFFFF_FF81 : 32'h80FF_7F81);
    cycle("lb0", 0, 0);
    apply_stimulus(1, 1, 5'd8, 2'd1, 3'b100, 2'd3, 32'h1, 32'h80FF_7F81, 32'h0, 32'h0,
                   ALIGN ? 32'h0000_0080 : 32'h80FF_7F81, ALIGN ? 32'h0000_0080 : 32'h80FF_7F81);
    cycle("lbu3", 0, 0);
    apply_stimulus(1, 1, 5'd8, 2'd1, 3'b001, 2'd2, 32'h1, 32'h80FF_7F81, 32'h0, 32'h0,
                   ALIGN ? 32'hFFFF_80FF : 32'h80FF_7F81, ALIGN ? 32'hFFFF_80FF : 32'h80FF_7F81);
    cycle("lh2", 0, 0);
    apply_stimulus(1, 1, 5'd8, 2'd1, 3'b101, 2'd0, 32'h1, 32'h80FF_7F81, 32'h0, 32'h0,
                   ALIGN ? 32'h0000_7F81 : 32'h80FF_7F81, ALIGN ? 32'h0000_7F81 : 32'h80FF_7F81);
    cycle("lhu0", 0, 0);
    apply_stimulus(1, 1, 5'd8, 2'd1, 3'b001, 2'd1, 32'h1, 32'h1234_8765, 32'h0, 32'h0,
                   ALIGN ? 32'hFFFF_8765 : 32'h1234_8765, ALIGN ? 32'hFFFF_8765 : 32'h1234_8765);
    cycle("lh1", 0, 0);
    apply_stimulus(1, 1, 5'd8, 2'd1, 3'b010, 2'd3, 32'h1, 32'h80FF_7F81, 32'h0, 32'h0,
                   32'h80FF_7F81, 32'h80FF_7F81);
    cycle("lw3", 0, 0);
    apply_stimulus(1, 1, 5'd8, 2'd1, 3'b011, 2'd1, 32'h1, 32'hC3A5_5A3C, 32'h0, 32'h0,
                   32'hC3A5_5A3C, 32'hC3A5_5A3C);
    cycle("ltraw", 0, 0);

    apply_stimulus(1, 1, 5'd0, 2'd0, 3'b010, 2'd0, 32'h0000_0077, 32'h0, 32'h0, 32'h0,
                   32'h0000_0077, 32'h0000_0077);
    cycle("x0", 0, 0);
    apply_stimulus(0, 1, 5'd9, 2'd0, 3'b010, 2'd0, 32'h0000_0099, 32'h0, 32'h0, 32'h0,
                   32'h0000_0099, 32'h0000_0099);
    cycle("invalid", 0, 0);

    // Stall three cycles: rd 10 stays on the outputs and retires once on release.
    apply_stimulus(1, 1, 5'd10, 2'd0, 3'b010, 2'd0, 32'h0000_0A0A, 32'h0, 32'h0, 32'h0,
                   32'h0000_0A0A, 32'h0000_0A0A);
    cycle("pre_stall", 0, 0);
    apply_stimulus(1, 1, 5'd11, 2'd3, 3'b010, 2'd0, 32'h0000_0B0B, 32'h0, 32'h0, 32'h1111_0000,
                   32'h1111_0000, 32'h0000_0B0B);
    cycle("stall1", 1, 0);
    cycle("stall2", 1, 0);
    cycle("stall3", 1, 0);
    cycle("unstall", 0, 0);

    apply_stimulus(1, 1, 5'd12, 2'd0, 3'b010, 2'd0, 32'h0000_0C0C, 32'h0, 32'h0, 32'h0,
                   32'h0000_0C0C, 32'h0000_0C0C);
    cycle("flush_stall", 1, 1);
    apply_stimulus(1, 1, 5'd13, 2'd2, 3'b010, 2'd0, 32'h0000_0D0D, 32'h0, 32'h0000_2000, 32'h0,
                   32'h0000_2000, 32'h0000_0D0D);
    cycle("pre_flush", 0, 0);
    apply_stimulus(1, 1, 5'd14, 2'd0, 3'b010, 2'd0, 32'h0000_0E0E, 32'h0, 32'h0, 32'h0,
                   32'h0000_0E0E, 32'h0000_0E0E);
    cycle("flush", 0, 1);
    apply_stimulus(1, 1, 5'd15, 2'd0, 3'b010, 2'd0, 32'h0000_0F0F, 32'h0, 32'h0, 32'h0,
                   32'h0000_0F0F, 32'h0000_0F0F);
    cycle("post_flush", 0, 0);

    // Asynchronous reset between edges clears state without waiting for the clock.
    #2;
    rst_n = 1'b0;
    #1;
    cur.valid = 1'b0; cur.regwrite = 1'b0; cur.rd = '0; cur.data4 = '0; cur.data2 = '0;
    exp_instret = '0;
    exp_q.delete();
    check_output("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(1, 1, 5'd16, 2'd0, 3'b010, 2'd0, 32'h0000_1010, 32'h0, 32'h0, 32'h0,
                   32'h0000_1010, 32'h0000_1010);
    cycle("after_reset", 0, 0);

    // Preload the counter to its maximum and retire the instruction in WB.
    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    check_val("preload instret", instret, exp_instret);
    apply_stimulus(1, 1, 5'd17, 2'd0, 3'b010, 2'd0, 32'h0000_1111, 32'h0, 32'h0, 32'h0,
                   32'h0000_1111, 32'h0000_1111);
    cycle("wrap", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised MEM/WB pipeline register and writeback stage for the RISC-V pipeline. It captures the MEM-stage result bundle on each clock, supports stall and flush, and selects among up to four writeback sources. It optionally aligns and sign/zero-extends load data, suppresses writes to x0, and keeps a 64-bit retired-instruction counter. It sits between the data-memory stage and the register file write port.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)
- NSRC, 4, number of writeback sources used (2..4)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_wb  in  1  hold WB register contents
- flush_wb  in  1  load a bubble into WB
- valid_mem  in  1  MEM stage holds a real instruction
- RegWrite_mem  in  1  instruction writes rd
- rd_mem  in  5  destination register
- WbSel_mem  in  2  source select: 0 ALU, 1 memory, 2 PC+4, 3 immediate
- LoadType_mem  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr_lo_mem  in  2  low two bits of the load address
- ALUResult_mem  in  XLEN  ALU result
- memDout_mem  in  XLEN  raw data-memory word
- PCPlus4_mem  in  XLEN  link address
- Imm_mem  in  XLEN  immediate (LUI)
- valid_wb  out  1  WB holds a real instruction
- RegWrite_wb  out  1  register-file write enable
- rd_wb  out  5  register-file write address
- RegWriteData_wb  out  XLEN  register-file write data
- instret  out  64  retired-instruction count

## Operation
- Clocking: single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Register update priority on each rising edge of clk:
  - flush_wb first: load a bubble (valid 0, RegWrite 0, all other fields 0).
  - then stall_wb: hold all fields.
  - otherwise: capture all *_mem inputs.
- Flush takes priority over stall when both are asserted.
- RegWrite_wb = registered RegWrite & registered valid & (rd_wb != 0). A write to x0 is never presented.
- Source select is combinational from registered fields: 0 ALU, 1 load data, 2 PC+4, 3 Imm.
  - A select value >= NSRC yields the ALU result.
  - With NSRC=2, behaviour is identical to a plain mem/ALU 2:1 mux.
- Load data (under WB_LOAD_ALIGN_EN):
  - Byte loads take byte addr_lo of the word.
  - Half loads take the upper half if addr_lo[1]=1, else the lower half; addr_lo[0] is ignored.
  - Word loads ignore addr_lo.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - Unlisted LoadType codes pass the raw word.
- instret increments by 1 on each rising edge where valid_wb=1 and stall_wb=0. It wraps from 2^64-1 to 0. It is not affected by flush_wb.

## Timing
- Latency: *_mem inputs appear on *_wb outputs one cycle later.
- RegWriteData_wb is combinational from WB registers: no extra cycle after the edge, valid within the same cycle.
- Reset values: valid_wb 0, RegWrite_wb 0, rd_wb 0, RegWriteData_wb 0 (ALU select of a zero result), instret 0.
- Reset asserted mid-operation clears all state immediately, independent of clk. The first capture occurs on the first rising edge after rst_n deasserts.
- A stalled valid instruction is presented with identical outputs for every stalled cycle and retires once, on the edge where stall_wb falls.
- The register file must write on the same edge on which the WB register advances. Downstream consumers rely on RegWrite_wb being 0 during bubbles.

## Configuration
- WB_LOAD_ALIGN_EN:
  - Defined: byte/half extraction and sign/zero extension as in Operation.
  - Undefined: memDout is used unmodified for source 1, and LoadType/addr_lo are not registered, so the block is pure word-load.

## Test plan
- Reset: rst_n=0 with inputs active -> all outputs 0. Release and drive ALUResult=0x0000_1234, WbSel=0, RegWrite=1, rd=5, valid=1 -> next cycle RegWriteData_wb=0x1234, RegWrite_wb=1, rd_wb=5.
- Load extension (EN defined): memDout=0x80FF_7F81.
  - LB addr_lo=0 -> 0xFFFF_FF81.
  - LBU addr_lo=3 -> 0x0000_0080.
  - LH addr_lo=2 -> 0xFFFF_80FF.
  - LHU addr_lo=0 -> 0x0000_7F81.
- Source select: WbSel=2 with PCPlus4=0x100 -> 0x100. WbSel=3 with Imm=0xABCD_E000 -> 0xABCD_E000. With NSRC=2, WbSel=3 -> ALU result.
- x0 suppression: RegWrite=1, rd=0 -> RegWrite_wb=0.
- Stall/flush:
  - stall_wb held 3 cycles -> outputs constant, instret +1 total.
  - flush and stall together -> valid_wb=0, RegWrite_wb=0.
- Counter wrap: force instret to 0xFFFF_FFFF_FFFF_FFFF, retire one instruction -> instret=0.
